mem_32_32: RTL and testbench



---
 rtl/mem_32_32_pkg.sv | 14 +
 rtl/mem_32_32.sv | 66 ++++++
 tb/tb_mem_32_32.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_32_32_pkg.sv
// mem_32_32_pkg: shared constants and types for the register-file array.
//   MEM_DATA_W : word width in bits
//   MEM_ADDR_W : address width in bits
//   MEM_DEPTH  : number of entries (2**MEM_ADDR_W)
//   word_t     : one datapath word
package mem_32_32_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

  typedef logic [MEM_DATA_W-1:0] word_t;

endpackage : mem_32_32_pkg

// File: rtl/mem_32_32.sv
// mem_32_32: 32 x 32-bit register file, two combinational read ports and
// one synchronous write port.
//
// Ports:
//   CLK   in  1       clock, writes on rising edge
//   RST_N in  1       asynchronous active-low reset, clears every entry
//   WE3   in  1       write enable for port 3
//   A1    in  ADDR_W  read address, port 1
//   A2    in  ADDR_W  read address, port 2
//   A3    in  ADDR_W  write address, port 3
//   WD3   in  DATA_W  write data, port 3
//   RD1   out DATA_W  mem[A1], combinational
//   RD2   out DATA_W  mem[A2], combinational
//
// Interface timing: there is no handshake. Every rising edge with RST_N=1
// and WE3=1 writes WD3 into entry A3; the reads follow the stored contents
// with zero latency and never stall.
module mem_32_32
  import mem_32_32_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Flip-flop storage so the whole array clears asynchronously and both
  // read ports can be plain muxes.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state: hold everything, overwrite only the addressed entry.
  // Entry 0 is ordinary storage, no hardwired zero.
  always_comb begin
    mem_d = mem_q;
    if (WE3) begin
      mem_d[A3] = WD3;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads come from the registered array only: a same-address write shows
  // up after the edge, never before it (no write-first bypass).
  assign RD1 = mem_q[A1];
  assign RD2 = mem_q[A2];

endmodule : mem_32_32

// File: tb/tb_mem_32_32.sv
// tb_mem_32_32: directed self-checking bench for mem_32_32. The driver
// pushes expected RD1/RD2 values into a queue and raises sample_ev; the
// monitor pops and compares against the DUT outputs.
module tb_mem_32_32;

  logic        CLK;
  logic        RST_N;
  logic        WE3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  event        sample_ev;

  mem_32_32 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .WE3   (WE3),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WD3   (WD3),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present read addresses, queue expectations, ask the monitor to sample.
  task automatic check_read(input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input string name);
    A1 = a1;
    A2 = a2;
    #1;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    name_q.push_back(name);
    -> sample_ev;
    #1;
  endtask

  // One write cycle; address is given wider than 5 bits and truncated.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                          input logic en);
    @(negedge CLK);
    WE3 = en;
    A3  = a[4:0];
    WD3 = d;
    @(posedge CLK);
    #1;
    WE3 = 1'b0;
  endtask

  function automatic logic [31:0] pattern(input int i);
    logic [31:0] p;
    p = 32'hC0DE_0000 + (i * 32'h0001_0101) + 32'd7;
    return p;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    string       n;
    forever begin
      @(sample_ev);
      checks++;
      if (exp_q.size() < 2 || name_q.size() < 1) begin
        errors++;
        $display("FAIL scoreboard_underflow got %0d entries need 2", exp_q.size());
      end else begin
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n  = name_q.pop_front();
        if (RD1 !== e1) begin
          errors++;
          $display("FAIL %s rd1 A1=%0d got %0d exp %0d", n, A1, RD1, e1);
        end
        checks++;
        if (RD2 !== e2) begin
          errors++;
          $display("FAIL %s rd2 A2=%0d got %0d exp %0d", n, A2, RD2, e2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    WE3   = 1'b0;
    A1    = '0;
    A2    = '0;
    A3    = '0;
    WD3   = '0;

    // Reset state: every address reads zero.
    #2;
    for (int i = 0; i < 32; i++) check_read(i[4:0], 5'(31 - i), 32'd0, 32'd0, "reset_init");
    @(negedge CLK);
    RST_N = 1'b1;

    // Entry 0 is writable.
    do_write(8'd0, 32'd30, 1'b1);
    check_read(5'd0, 5'd0, 32'd30, 32'd30, "entry0");

    // Address truncation: 42 -> 10, 100 -> 4.
    do_write(8'd42, 32'd228, 1'b1);
    do_write(8'd21, 32'd1337, 1'b1);
    check_read(5'd10, 5'd21, 32'd228, 32'd1337, "trunc_42_21");
    do_write(8'd100, 32'd1488, 1'b1);
    check_read(5'd10, 5'd4, 32'd228, 32'd1488, "trunc_100");

    // Write disabled: entry 21 keeps 1337.
    do_write(8'd21, 32'd7, 1'b0);
    check_read(5'd21, 5'd0, 32'd1337, 32'd30, "write_disable");

    // Read-during-write on entry 5 (old value 0).
    @(negedge CLK);
    A3  = 5'd5;
    WD3 = 32'd99;
    WE3 = 1'b1;
    check_read(5'd5, 5'd5, 32'd0, 32'd0, "rdw_before");
    @(posedge CLK);
    #1;
    WE3 = 1'b0;
    check_read(5'd5, 5'd5, 32'd99, 32'd99, "rdw_after");

    // Dual-port same address.
    check_read(5'd21, 5'd21, 32'd1337, 32'd1337, "dual_same");

    // Sweep: unique pattern per entry, check both ports.
    for (int i = 0; i < 32; i++) do_write(8'(i), pattern(i), 1'b1);
    for (int i = 0; i < 32; i++) check_read(i[4:0], 5'(31 - i), pattern(i), pattern(31 - i), "sweep");
    for (int i = 0; i < 32; i++) check_read(i[4:0], i[4:0], pattern(i), pattern(i), "sweep_same");

    // Mid-run asynchronous reset with a write attempted during it.
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    WE3   = 1'b1;
    A3    = 5'd3;
    WD3   = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) check_read(i[4:0], 5'(31 - i), 32'd0, 32'd0, "reset_low");
    @(negedge CLK);
    RST_N = 1'b1;
    WE3   = 1'b0;
    for (int i = 0; i < 32; i++) check_read(i[4:0], 5'(31 - i), 32'd0, 32'd0, "reset_after");

    // First write accepted on the first edge after release.
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    @(negedge CLK);
    RST_N = 1'b1;
    WE3   = 1'b1;
    A3    = 5'd7;
    WD3   = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    WE3 = 1'b0;
    check_read(5'd7, 5'd3, 32'hDEAD_BEEF, 32'd0, "first_write");

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 100;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge CLK);
        budget--;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending=%0d exp 0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_32_32
